// File: rtl/beta_fetch_unit_if.sv
// Instruction-memory request/response bus used by the Bourbon fetch stage.
// One request outstanding at a time: req/addr until gnt, then a single rvalid.
interface beta_fetch_unit_if #(
    parameter int DataWidth = 32
);
    logic                 req;
    logic [DataWidth-1:0] addr;
    logic                 gnt;
    logic                 rvalid;
    logic [DataWidth-1:0] rdata;
    logic                 err;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata,
        output err
    );
endinterface

// File: rtl/beta_fetch_unit.sv
// Instruction fetch stage of the Bourbon pipeline: holds the PC, fetches one word
// at a time from instruction memory and hands it to decode; honours redirects.
module beta_fetch_unit #(
    parameter int                   DataWidth     = 32,
    parameter logic [DataWidth-1:0] BootAddr      = '0,
    parameter int                   TimeoutCycles = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 fetch_en_i,
    output logic                 busy_o,
    input  logic                 redirect_i,
    input  logic [DataWidth-1:0] redirect_addr_i,
    input  logic                 instr_ack_i,
    output logic [DataWidth-1:0] instr_o,
    output logic [DataWidth-1:0] instr_pc_o,
    output logic                 instr_valid_o,
    beta_fetch_unit_if.master    imem,
    output logic                 fault_o
);

    localparam int                   CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [DataWidth-1:0] NopInstr = DataWidth'(32'h0000_0013);
    localparam logic [CntWidth-1:0]  CntLast  = CntWidth'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } state_t;

    state_t               state_reg, state_next;
    logic [DataWidth-1:0] pc_reg, pc_next;
    logic [DataWidth-1:0] addr_reg, addr_next;
    logic [DataWidth-1:0] instr_reg, instr_next;
    logic [DataWidth-1:0] instr_pc_reg, instr_pc_next;
    logic                 valid_reg, valid_next;
    logic                 fault_reg, fault_next;
    logic                 drop_reg, drop_next;
    logic [CntWidth-1:0]  cnt_reg, cnt_next;

    logic [DataWidth-1:0] target;
    logic                 timeout;

    assign target  = redirect_addr_i & ~DataWidth'(3);
    assign timeout = (cnt_reg == CntLast);

    // addr_reg keeps the in-flight address stable even if a redirect moves the PC.
    assign busy_o        = (state_reg != IDLE);
    assign imem.req      = (state_reg == REQ);
    assign imem.addr     = (state_reg == REQ) ? addr_reg : pc_reg;
    assign instr_o       = instr_reg;
    assign instr_pc_o    = instr_pc_reg;
    assign instr_valid_o = valid_reg;
    assign fault_o       = fault_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            pc_reg       <= BootAddr;
            addr_reg     <= BootAddr;
            instr_reg    <= NopInstr;
            instr_pc_reg <= '0;
            valid_reg    <= 1'b0;
            fault_reg    <= 1'b0;
            drop_reg     <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            addr_reg     <= addr_next;
            instr_reg    <= instr_next;
            instr_pc_reg <= instr_pc_next;
            valid_reg    <= valid_next;
            fault_reg    <= fault_next;
            drop_reg     <= drop_next;
            cnt_reg      <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        addr_next     = addr_reg;
        instr_next    = instr_reg;
        instr_pc_next = instr_pc_reg;
        valid_next    = valid_reg;
        fault_next    = fault_reg;
        drop_next     = drop_reg;
        cnt_next      = cnt_reg;

        // An ack consumes the word; a response written this cycle overrides it below.
        if (instr_ack_i) begin
            valid_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (fetch_en_i && !fault_reg && (redirect_i || !valid_reg || instr_ack_i)) begin
                    state_next = REQ;
                    addr_next  = redirect_i ? target : pc_reg;
                    drop_next  = 1'b0;
                end
            end
            REQ: begin
                if (redirect_i) begin
                    drop_next = 1'b1;
                end
                if (imem.gnt) begin
                    state_next = (drop_reg || redirect_i) ? DROP : WAIT;
                    cnt_next   = '0;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg + CntWidth'(1);
                if (imem.rvalid) begin
                    state_next = IDLE;
                    if (!redirect_i) begin
                        if (imem.err) begin
                            fault_next = 1'b1;
                        end else begin
                            instr_next    = imem.rdata;
                            instr_pc_next = addr_reg;
                            valid_next    = 1'b1;
                            pc_next       = addr_reg + DataWidth'(4);
                        end
                    end
                end else if (timeout) begin
                    fault_next = 1'b1;
                    state_next = IDLE;
                end else if (redirect_i) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                cnt_next = cnt_reg + CntWidth'(1);
                if (imem.rvalid) begin
                    state_next = IDLE;
                end else if (timeout) begin
                    fault_next = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (redirect_i) begin
            valid_next = 1'b0;
            pc_next    = target;
        end
    end

endmodule
